// File: rtl/ps2_cmd_sequencer.sv
// ps2_cmd_sequencer
//   Sits between application logic and ps2_controller. Runs the device
//   power-up sequence (0xFF reset, ACK, BAT), serialises one- and two-byte
//   host commands, and waits for the device ACK. It retries on RESEND (0xFE),
//   on transfer errors and on ACK timeouts, up to MAX_RETRIES times per byte.
//   Every other received byte is queued in a show-ahead rx FIFO.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   ps2_en              controller enable, high from the first edge after reset
//   ps2_tx_rqst         1-cycle transmit request to the controller
//   ps2_tx_data         byte to transmit, held until the next request
//   ps2_valid           controller strobe: tx done / rx byte available
//   ps2_rx_data         received byte
//   ps2_flags           controller error flags (layout of ps2_pkg::flags_t);
//                       any set bit marks the transfer as failed
//   cmd_valid/cmd_ready command handshake
//   cmd_byte, cmd_has_arg, cmd_arg   command byte and optional argument
//   cmd_done, cmd_err   1-cycle completion pulse, err = retries exhausted
//   rx_valid/rx_ready   rx FIFO pop handshake, rx_byte = FIFO head
//   rx_overflow         sticky, a byte was lost to a full FIFO
//   rx_drop             1-cycle pulse, a flagged rx byte was discarded
//   init_done, init_ok  power-up sequence finished / BAT 0xAA seen
module ps2_cmd_sequencer #(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned ACK_TIMEOUT_US = 20_000,
  parameter int unsigned BAT_TIMEOUT_US = 1_000_000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned INIT_RESET     = 1,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       ps2_en,
  output logic       ps2_tx_rqst,
  output logic [7:0] ps2_tx_data,
  input  logic       ps2_valid,
  input  logic [7:0] ps2_rx_data,
  input  logic [3:0] ps2_flags,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_overflow,
  output logic       rx_drop,
  output logic       init_done,
  output logic       init_ok
);

  localparam int unsigned TICK_DIV = (CLK_FREQ_HZ >= 1_000_000) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int unsigned PRE_W    = $clog2(TICK_DIV) + 1;
  localparam int unsigned ACK_W    = $clog2(ACK_TIMEOUT_US) + 1;
  localparam int unsigned BAT_W    = $clog2(BAT_TIMEOUT_US) + 1;
  localparam int unsigned TO_W     = (ACK_W > BAT_W) ? ACK_W : BAT_W;
  localparam int unsigned RTY_W    = $clog2(MAX_RETRIES) + 1;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef enum logic [2:0] {RST_TX, IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT} state_t;
  typedef enum logic [1:0] {PH_INIT, PH_CMD, PH_ARG} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q;
  logic [7:0]       cur_byte_q, arg_q;
  logic             has_arg_q;
  logic [RTY_W-1:0] retry_q;
  logic [PRE_W-1:0] pre_q;
  logic [TO_W-1:0]  to_q;
  logic             en_q;

  // Control strobes from the next-state logic
  logic rx_ok, rx_bad, retry_req, can_retry;
  logic load_ff, load_cmd, go_arg, bump, tmr_clr;
  logic push, drop, done_set, err_val, init_fin, init_good;
  logic ack_expired, bat_expired;

  // FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full, pop, wr_en;

  logic done_q, err_q, drop_q, ovf_q, init_done_q, init_ok_q;

  assign ack_expired = (to_q >= TO_W'(ACK_TIMEOUT_US));
  assign bat_expired = (to_q >= TO_W'(BAT_TIMEOUT_US));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= (INIT_RESET != 0) ? RST_TX : IDLE;
    else        state_q <= state_d;
  end

  // Next state and control strobes
  always_comb begin
    state_d   = state_q;
    rx_ok     = ps2_valid && (ps2_flags == '0);
    rx_bad    = ps2_valid && (ps2_flags != '0);
    can_retry = (retry_q < RTY_W'(MAX_RETRIES));
    retry_req = 1'b0;
    load_ff   = 1'b0;
    load_cmd  = 1'b0;
    go_arg    = 1'b0;
    bump      = 1'b0;
    tmr_clr   = 1'b0;
    push      = 1'b0;
    drop      = 1'b0;
    done_set  = 1'b0;
    err_val   = 1'b0;
    init_fin  = 1'b0;
    init_good = 1'b0;
    unique case (state_q)
      RST_TX: begin
        load_ff = 1'b1;
        state_d = SEND;
      end
      IDLE: begin
        push = rx_ok;
        drop = rx_bad;
        if (cmd_valid && en_q) begin
          load_cmd = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (rx_ok) begin
          tmr_clr = 1'b1;
          state_d = WAIT_ACK;
        end else if (rx_bad) begin
          retry_req = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (rx_ok) begin
          if (ps2_rx_data == 8'hFA) begin
            if (phase_q == PH_CMD && has_arg_q) begin
              go_arg  = 1'b1;
              state_d = SEND;
            end else if (phase_q == PH_INIT) begin
              tmr_clr = 1'b1;
              state_d = WAIT_BAT;
            end else begin
              done_set = 1'b1;
              state_d  = IDLE;
            end
          end else if (ps2_rx_data == 8'hFE) begin
            retry_req = 1'b1;
          end else begin
            push = 1'b1;
          end
        end else if (rx_bad) begin
          drop = 1'b1;
        end else if (ack_expired) begin
          retry_req = 1'b1;
        end
      end
      WAIT_BAT: begin
        if (rx_ok) begin
          if (ps2_rx_data == 8'hAA) begin
            init_fin  = 1'b1;
            init_good = 1'b1;
            state_d   = IDLE;
          end else if (ps2_rx_data == 8'hFC) begin
            init_fin = 1'b1;
            state_d  = IDLE;
          end else begin
            push = 1'b1;
          end
        end else if (rx_bad) begin
          drop = 1'b1;
        end else if (bat_expired) begin
          init_fin = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared retry/fail handling for every failure source
    if (retry_req) begin
      if (can_retry) begin
        bump    = 1'b1;
        state_d = SEND;
      end else begin
        state_d = IDLE;
        if (phase_q == PH_INIT) begin
          init_fin = 1'b1;
        end else begin
          done_set = 1'b1;
          err_val  = 1'b1;
        end
      end
    end
  end

  // Moore outputs
  always_comb begin
    ps2_tx_rqst = (state_q == SEND);
    cmd_ready   = (state_q == IDLE) && en_q;
  end

  // Byte context, timers and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      phase_q     <= PH_INIT;
      cur_byte_q  <= '0;
      arg_q       <= '0;
      has_arg_q   <= 1'b0;
      retry_q     <= '0;
      pre_q       <= '0;
      to_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      init_done_q <= 1'b0;
      init_ok_q   <= 1'b0;
    end else begin
      en_q   <= 1'b1;
      done_q <= done_set;
      err_q  <= done_set && err_val;
      drop_q <= drop;
      if (load_ff) begin
        cur_byte_q <= 8'hFF;
        phase_q    <= PH_INIT;
        retry_q    <= '0;
      end
      if (load_cmd) begin
        cur_byte_q <= cmd_byte;
        arg_q      <= cmd_arg;
        has_arg_q  <= cmd_has_arg;
        phase_q    <= PH_CMD;
        retry_q    <= '0;
      end
      if (go_arg) begin
        cur_byte_q <= arg_q;
        phase_q    <= PH_ARG;
        retry_q    <= '0;
      end
      if (bump) retry_q <= retry_q + RTY_W'(1);
      if (init_fin) begin
        init_done_q <= 1'b1;
        init_ok_q   <= init_good;
      end
      // Prescaler restarts with the timeout so every wait is exactly N ticks
      if (tmr_clr) begin
        pre_q <= '0;
        to_q  <= '0;
      end else if (pre_q == PRE_W'(TICK_DIV - 1)) begin
        pre_q <= '0;
        if (to_q != '1) to_q <= to_q + TO_W'(1);
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
    end
  end

  // rx FIFO: a push into a full FIFO is accepted only if a pop frees a slot
  assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign rx_valid  = (fifo_cnt != '0);
  assign pop       = rx_valid && rx_ready;
  assign wr_en     = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= ps2_rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (pop && !wr_en) fifo_cnt <= fifo_cnt - CNT_W'(1);
      if (push && !wr_en) ovf_q <= 1'b1;
    end
  end

  assign ps2_en      = en_q;
  assign ps2_tx_data = cur_byte_q;
  assign cmd_done    = done_q;
  assign cmd_err     = err_q;
  assign rx_byte     = rx_valid ? mem[rd_ptr] : '0;
  assign rx_overflow = ovf_q;
  assign rx_drop     = drop_q;
  assign init_done   = init_done_q;
  assign init_ok     = init_ok_q;

endmodule
